// File: rtl/simple_proc_pkg.sv
// simple_proc_pkg
// Shared types and constants for the simple processor control unit.
//   opcode_t : 3-bit instruction opcodes (mv, mvi, add, sub)
//   tstep_t  : timestep encoding T0..T3
//   IW       : instruction width (III XXX YYY)
//   NREG     : number of general registers R0..R(NREG-1)
//   SEL_DIN / SEL_G : bus mux selects for DIN and the G register
package simple_proc_pkg;

  localparam int IW   = 9;
  localparam int NREG = 6;

  localparam logic [2:0] SEL_DIN = 3'd6;
  localparam logic [2:0] SEL_G   = 3'd7;

  typedef enum logic [2:0] {
    OP_MV  = 3'b000,
    OP_MVI = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011
  } opcode_t;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } tstep_t;

endpackage

// File: rtl/simple_proc_ctrl_regsel_dec.sv
// regsel_dec
// Combinational 3-bit register index to NREG-wide one-hot write enable.
// Ports:
//   en           : in  1    - gates every output bit
//   idx          : in  3    - register index
//   onehot       : out NREG - one-hot enable (all zero when en=0 or idx out of range)
//   out_of_range : out 1    - idx does not name an existing register
module regsel_dec
  import simple_proc_pkg::*;
(
  input  logic            en,
  input  logic [2:0]      idx,
  output logic [NREG-1:0] onehot,
  output logic            out_of_range
);

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_bit
      assign onehot[gi] = en && (idx == 3'(gi));
    end
  endgenerate

  assign out_of_range = (idx >= 3'(NREG));

endmodule

// File: rtl/simple_proc_ctrl.sv
// simple_proc_ctrl
// Control unit for the simple processor datapath. Latches a 9-bit
// instruction from DIN on Run (in T0) and steps T0..T3, driving the bus
// select and the register / accumulator / ALU enables for each step.
// Optional build macro SIMPLE_PROC_ILLEGAL_EN adds Illegal and IllegalSticky.
// Ports:
//   Clock         : in  1    - system clock
//   Reset         : in  1    - synchronous active-high reset
//   Run           : in  1    - start request, sampled only in T0
//   DIN           : in  IW   - instruction word / mvi immediate
//   BusSel        : out 3    - bus mux select (0..5 = R0..R5, 6 = DIN, 7 = G)
//   Rin           : out NREG - one-hot register write enable
//   Ain, Gin      : out 1    - ALU operand / result register load
//   AddSub        : out 1    - 0 = add, 1 = subtract
//   IRin          : out 1    - instruction register load strobe
//   Done          : out 1    - pulse on the final step of an instruction
//   Illegal       : out 1    - (macro only) pulses with Done on illegal decode
//   IllegalSticky : out 1    - (macro only) set by an illegal decode until Reset
// IW and NREG are fixed in simple_proc_pkg.
module simple_proc_ctrl
  import simple_proc_pkg::*;
(
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Run,
  input  logic [IW-1:0]   DIN,
  output logic [2:0]      BusSel,
  output logic [NREG-1:0] Rin,
  output logic            Ain,
  output logic            Gin,
  output logic            AddSub,
  output logic            IRin,
  output logic            Done
`ifdef SIMPLE_PROC_ILLEGAL_EN
  ,
  output logic            Illegal,
  output logic            IllegalSticky
`endif
);

  tstep_t        state_reg, state_next;
  logic [IW-1:0] ir_reg;

  logic [2:0] op, x, y;
  logic       x_bad, y_bad, illegal_dec;
  logic       rin_en;

  assign op = ir_reg[IW-1:6];
  assign x  = ir_reg[5:3];
  assign y  = ir_reg[2:0];

  // Rin always targets the X field; the decoder also reports X out of range.
  regsel_dec u_regsel (
    .en           (rin_en),
    .idx          (x),
    .onehot       (Rin),
    .out_of_range (x_bad)
  );

  assign y_bad = (y >= 3'(NREG));

  always_comb begin
    illegal_dec = 1'b1;
    case (op)
      OP_MV:          illegal_dec = x_bad || y_bad;
      OP_MVI:         illegal_dec = x_bad;
      OP_ADD, OP_SUB: illegal_dec = x_bad || y_bad;
      default:        illegal_dec = 1'b1;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg <= T0;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (IRin) ir_reg <= DIN;
    end
  end

  always_comb begin
    state_next = state_reg;
    BusSel     = 3'd0;
    rin_en     = 1'b0;
    Ain        = 1'b0;
    Gin        = 1'b0;
    AddSub     = 1'b0;
    IRin       = 1'b0;
    Done       = 1'b0;
    case (state_reg)
      T0: begin
        IRin = Run;
        if (Run) state_next = T1;
      end
      T1: begin
        if (illegal_dec) begin
          // Illegal instructions retire as no-ops: Done only, no enables.
          Done       = 1'b1;
          state_next = T0;
        end else begin
          case (op)
            OP_MV: begin
              BusSel     = y;
              rin_en     = 1'b1;
              Done       = 1'b1;
              state_next = T0;
            end
            OP_MVI: begin
              BusSel     = SEL_DIN;
              rin_en     = 1'b1;
              Done       = 1'b1;
              state_next = T0;
            end
            OP_ADD, OP_SUB: begin
              BusSel     = x;
              Ain        = 1'b1;
              state_next = T2;
            end
            default: begin
              Done       = 1'b1;
              state_next = T0;
            end
          endcase
        end
      end
      T2: begin
        BusSel     = y;
        Gin        = 1'b1;
        AddSub     = ir_reg[6];  // low opcode bit distinguishes sub from add
        state_next = T3;
      end
      T3: begin
        BusSel     = SEL_G;
        rin_en     = 1'b1;
        Done       = 1'b1;
        state_next = T0;
      end
    endcase
  end

`ifdef SIMPLE_PROC_ILLEGAL_EN
  logic illegal_now;
  logic sticky_reg;

  assign illegal_now = (state_reg == T1) && illegal_dec;

  always_ff @(posedge Clock) begin
    if (Reset)            sticky_reg <= 1'b0;
    else if (illegal_now) sticky_reg <= 1'b1;
  end

  assign Illegal       = illegal_now;
  assign IllegalSticky = sticky_reg;
`endif

endmodule

// File: tb/tb_simple_proc_ctrl.sv
// tb_simple_proc_ctrl
// Directed bench for simple_proc_ctrl. A model turns each accepted
// instruction into its list of per-cycle bus/enable expectations; a compare
// process checks every non-reset cycle against that list, and the stimulus
// process adds literal checks at key points of the instruction sequences.
module tb_simple_proc_ctrl;

  logic       Clock;
  logic       Reset;
  logic       Run;
  logic [8:0] DIN;
  logic [2:0] BusSel;
  logic [5:0] Rin;
  logic       Ain, Gin, AddSub, IRin, Done;
`ifdef SIMPLE_PROC_ILLEGAL_EN
  logic       Illegal, IllegalSticky;
`endif

  simple_proc_ctrl dut (
    .Clock  (Clock),
    .Reset  (Reset),
    .Run    (Run),
    .DIN    (DIN),
    .BusSel (BusSel),
    .Rin    (Rin),
    .Ain    (Ain),
    .Gin    (Gin),
    .AddSub (AddSub),
    .IRin   (IRin),
    .Done   (Done)
`ifdef SIMPLE_PROC_ILLEGAL_EN
    ,
    .Illegal       (Illegal),
    .IllegalSticky (IllegalSticky)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    logic [2:0] bus;
    logic [5:0] rin;
    logic       ain;
    logic       gin;
    logic       addsub;
    logic       done;
    logic       ill;
  } exp_t;

  exp_t q[$];
  logic model_on = 1'b0;
  logic sticky_m = 1'b0;

  // Expand an instruction into the cycles that follow its acceptance.
  task automatic plan(input logic [8:0] d);
    int   op, x, y;
    logic illegal;
    exp_t e;
    op = int'(d[8:6]);
    x  = int'(d[5:3]);
    y  = int'(d[2:0]);
    case (op)
      0, 2, 3: illegal = (x >= 6) || (y >= 6);
      1:       illegal = (x >= 6);
      default: illegal = 1'b1;
    endcase
    $display("issue din=%b op=%0d x=%0d y=%0d illegal=%0d", d, op, x, y, illegal);
    e = '0;
    if (illegal) begin
      e.done = 1'b1; e.ill = 1'b1;
      q.push_back(e);
    end else if (op == 0 || op == 1) begin
      e.bus  = (op == 0) ? 3'(y) : 3'd6;
      e.rin  = 6'(1 << x);
      e.done = 1'b1;
      q.push_back(e);
    end else begin
      e = '0; e.bus = 3'(x); e.ain = 1'b1;
      q.push_back(e);
      e = '0; e.bus = 3'(y); e.gin = 1'b1; e.addsub = (op == 3);
      q.push_back(e);
      e = '0; e.bus = 3'd7; e.rin = 6'(1 << x); e.done = 1'b1;
      q.push_back(e);
    end
  endtask

  always @(negedge Clock) begin
    exp_t e;
    logic irin_e;
    if (model_on && !Reset) begin
      if (q.size() > 0) begin
        e = q[0]; irin_e = 1'b0;
      end else begin
        e = '0; irin_e = Run;
      end
      chk("BusSel", int'(BusSel), int'(e.bus));
      chk("Rin",    int'(Rin),    int'(e.rin));
      chk("Ain",    int'(Ain),    int'(e.ain));
      chk("Gin",    int'(Gin),    int'(e.gin));
      chk("AddSub", int'(AddSub), int'(e.addsub));
      chk("Done",   int'(Done),   int'(e.done));
      chk("IRin",   int'(IRin),   int'(irin_e));
`ifdef SIMPLE_PROC_ILLEGAL_EN
      chk("Illegal",       int'(Illegal),       int'(e.ill));
      chk("IllegalSticky", int'(IllegalSticky), int'(sticky_m));
`endif
    end
    // advance model to the state after the coming rising edge
    if (Reset) begin
      q.delete();
      sticky_m = 1'b0;
      model_on = 1'b1;
    end else if (model_on) begin
      if (q.size() > 0) begin
        if (q[0].ill) sticky_m = 1'b1;
        void'(q.pop_front());
      end else if (Run) begin
        plan(DIN);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Drive one cycle's inputs just after the rising edge, return at the
  // falling edge so the caller can inspect that cycle's outputs.
  task automatic go(input logic rst, input logic run, input logic [8:0] din);
    @(posedge Clock);
    #1;
    Reset = rst;
    Run   = run;
    DIN   = din;
    @(negedge Clock);
  endtask

  logic [8:0] tbl [10];

  initial begin
    Reset = 1'b1; Run = 1'b0; DIN = '0;
    tbl = '{9'b010_101_011, 9'b011_000_101, 9'b001_111_000, 9'b010_000_110,
            9'b000_101_111, 9'b011_010_010, 9'b000_000_000, 9'b100_011_001,
            9'b001_101_001, 9'b011_101_100};

    // reset held two cycles, then idle
    go(1'b1, 1'b0, 9'd0);
    go(1'b1, 1'b0, 9'd0);
    for (int i = 0; i < 5; i++) begin
      go(1'b0, 1'b0, 9'd0);
      chk("idle_done", int'(Done), 0);
      chk("idle_bus",  int'(BusSel), 0);
      chk("idle_rin",  int'(Rin), 0);
    end

    // mvi R2
    go(1'b0, 1'b1, 9'b001_010_000);
    chk("mvi_irin", int'(IRin), 1);
    go(1'b0, 1'b0, 9'd0);
    chk("mvi_bus",  int'(BusSel), 6);
    chk("mvi_rin",  int'(Rin), 6'b000100);
    chk("mvi_done", int'(Done), 1);
    go(1'b0, 1'b0, 9'd0);
    chk("mvi_back_t0", int'(Done), 0);

    // mv R1,R4 followed by sub R3,R0 with Run held high
    go(1'b0, 1'b1, 9'b000_001_100);
    go(1'b0, 1'b1, 9'b011_011_000);
    chk("mv_bus",  int'(BusSel), 4);
    chk("mv_rin",  int'(Rin), 6'b000010);
    chk("mv_done", int'(Done), 1);
    go(1'b0, 1'b1, 9'b011_011_000);
    chk("b2b_irin", int'(IRin), 1);
    go(1'b0, 1'b0, 9'd0);
    chk("sub_t1_bus", int'(BusSel), 3);
    chk("sub_t1_ain", int'(Ain), 1);
    go(1'b0, 1'b0, 9'd0);
    chk("sub_t2_bus", int'(BusSel), 0);
    chk("sub_t2_gin", int'(Gin), 1);
    chk("sub_t2_as",  int'(AddSub), 1);
    go(1'b0, 1'b0, 9'd0);
    chk("sub_t3_bus",  int'(BusSel), 7);
    chk("sub_t3_rin",  int'(Rin), 6'b001000);
    chk("sub_t3_done", int'(Done), 1);

    // add R0,R5 aborted by Reset in T2
    go(1'b0, 1'b1, 9'b010_000_101);
    go(1'b0, 1'b0, 9'd0);
    go(1'b1, 1'b0, 9'd0);
    go(1'b0, 1'b0, 9'd0);
    chk("abort_gin",  int'(Gin), 0);
    chk("abort_rin",  int'(Rin), 0);
    chk("abort_done", int'(Done), 0);
    go(1'b0, 1'b1, 9'b001_000_000);
    go(1'b0, 1'b0, 9'd0);
    chk("mvi0_rin",  int'(Rin), 6'b000001);
    chk("mvi0_done", int'(Done), 1);

    // Reset has priority over Run in T0
    go(1'b1, 1'b1, 9'b001_001_000);
    go(1'b0, 1'b0, 9'd0);
    chk("rst_prio_done", int'(Done), 0);

    // illegal opcode, then mv R6,R0
    go(1'b0, 1'b1, 9'b111_000_000);
    go(1'b0, 1'b0, 9'd0);
    chk("ill_done", int'(Done), 1);
    chk("ill_rin",  int'(Rin), 0);
`ifdef SIMPLE_PROC_ILLEGAL_EN
    chk("ill_pulse", int'(Illegal), 1);
`endif
    go(1'b0, 1'b1, 9'b000_110_000);
    go(1'b0, 1'b0, 9'd0);
    chk("mvr6_done", int'(Done), 1);
    chk("mvr6_rin",  int'(Rin), 0);
    go(1'b0, 1'b0, 9'd0);
    go(1'b0, 1'b0, 9'd0);
`ifdef SIMPLE_PROC_ILLEGAL_EN
    chk("sticky_hold", int'(IllegalSticky), 1);
    go(1'b1, 1'b0, 9'd0);
    go(1'b0, 1'b0, 9'd0);
    chk("sticky_clr", int'(IllegalSticky), 0);
`endif

    // add R2,R1 with Run low, then again with Run toggling mid-instruction
    go(1'b0, 1'b1, 9'b010_010_001);
    go(1'b0, 1'b0, 9'd0);
    go(1'b0, 1'b0, 9'd0);
    go(1'b0, 1'b0, 9'd0);
    chk("addq_rin", int'(Rin), 6'b000100);
    chk("addq_done", int'(Done), 1);
    go(1'b0, 1'b1, 9'b010_010_001);
    go(1'b0, 1'b0, 9'b000_000_011);
    chk("addt_t1_bus", int'(BusSel), 2);
    go(1'b0, 1'b1, 9'b001_100_000);
    chk("addt_t2_bus", int'(BusSel), 1);
    chk("addt_t2_as",  int'(AddSub), 0);
    chk("addt_t2_irin", int'(IRin), 0);
    go(1'b0, 1'b1, 9'b011_001_001);
    chk("addt_t3_rin",  int'(Rin), 6'b000100);
    chk("addt_t3_done", int'(Done), 1);
    chk("addt_t3_irin", int'(IRin), 0);
    go(1'b0, 1'b0, 9'd0);
    chk("addt_t0_irin", int'(IRin), 0);
    go(1'b0, 1'b0, 9'd0);

    // table of mixed instructions, each followed by idle cycles
    for (int i = 0; i < 10; i++) begin
      go(1'b0, 1'b1, tbl[i]);
      for (int k = 0; k < 4; k++) go(1'b0, 1'b0, 9'd0);
    end

    go(1'b0, 1'b0, 9'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/simple_proc_ctrl.md
Name: simple_proc_ctrl

Overview:
Control unit for the simple processor datapath. It registers a 9-bit instruction from DIN when Run is asserted, then sequences through timesteps T0..T3. In each timestep it drives the 3-bit bus select that feeds the datapath's 16-bit 8:1 bus multiplexer, plus the register, accumulator and ALU enables. Done pulses on the last step of each instruction.

Parameters:
IW, 9, instruction width (3-bit opcode + 3-bit X field + 3-bit Y field)
NREG, 6, number of general registers R0..R(NREG-1); bus sources 0..5 = R0..R5, 6 = DIN, 7 = G

Ports:
Clock  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high; forces FSM to T0 and clears IR
Run  input  1  start request; sampled only in T0
DIN  input  IW  instruction word (III XXX YYY); also the bus source for mvi immediate
BusSel  output  3  select for the datapath 8:1 bus mux
Rin  output  NREG  one-hot write enable for R0..R5
Ain  output  1  load enable for ALU operand register A
Gin  output  1  load enable for ALU result register G
AddSub  output  1  0 = add, 1 = subtract
IRin  output  1  instruction register load strobe (observable)
Done  output  1  one-cycle pulse on the final step of an instruction

Behaviour:
- One clock (Clock). Reset is synchronous and active-high (Reset). State is a 2-bit timestep register T0..T3; IR is internal, IW bits.
- Outputs are combinational from state, IR and Run. Default value of every output in every state is 0 unless listed below.
- Reset: next edge gives state=T0, IR=0. In T0 with Run=0, all outputs are 0 and BusSel=0.
- T0: IRin=Run. If Run=1: IR<=DIN, go to T1. Otherwise stay in T0.
- T1, decoded from IR; X=IR[5:3], Y=IR[2:0]:
  - op 000 (mv): BusSel=Y, Rin[X]=1, Done=1, go to T0.
  - op 001 (mvi): BusSel=6 (DIN), Rin[X]=1, Done=1, go to T0.
  - op 010 (add) / 011 (sub): BusSel=X, Ain=1, go to T2.
  - Illegal (op 100..111, X>=NREG, or Y>=NREG for mv/add/sub): no enables, Done=1, go to T0.
- T2: BusSel=Y, Gin=1, AddSub=IR[6], go to T3.
- T3: BusSel=7 (G), Rin[X]=1, Done=1, go to T0.
- Latency from Run accepted (T0) to Done: mv/mvi/illegal = 1 cycle; add/sub = 3 cycles.
- Run outside T0 is ignored; the IR is stable for the whole instruction.
- Back-to-back: Run high in the T0 cycle right after Done starts the next instruction with no bubble.
- Reset in T1..T3 aborts the instruction: next cycle T0, no Done, no enables. Reset has priority over Run.
- At most one Rin bit is high in any cycle. Ain, Gin and Rin are never high together.

Optional Feature:
SIMPLE_PROC_ILLEGAL_EN
- Defined: adds output Illegal (1 bit). It pulses together with Done on an illegal decode. It also sets a sticky output IllegalSticky, cleared only by Reset.
- Undefined: neither port exists. Illegal instructions still complete as no-ops with Done.

Decomposition:
- Package simple_proc_pkg holds:
  - opcode enum: OP_MV=3'b000, OP_MVI=3'b001, OP_ADD=3'b010, OP_SUB=3'b011
  - timestep enum: T0..T3
  - constants SEL_DIN=3'd6, SEL_G=3'd7, NREG=6
- One sub-module, regsel_dec: combinational 3-bit to NREG one-hot decoder with an enable input. It generates Rin and flags out-of-range indices.

Test Plan:
- Reset held 2 cycles, then released with Run=0 -> state T0, all outputs 0, Done never asserts over 5 cycles.
- Run=1, DIN=9'b001_010_000 (mvi R2) -> next cycle BusSel=6, Rin=6'b000100, Done=1; then T0.
- mv R1,R4 (DIN=9'b000_001_100) immediately followed by sub R3,R0 (9'b011_011_000) with Run held -> T1: BusSel=4, Rin=000010, Done; then BusSel=3, Ain; BusSel=0, Gin, AddSub=1; BusSel=7, Rin=001000, Done; no idle cycle between instructions.
- add R0,R5 with Reset pulsed during T2 -> next cycle T0, Gin/Rin/Done all 0; a following mvi R0 executes normally.
- Illegal DIN=9'b111_000_000 and mv R6,R0 -> Done after 1 cycle, Rin=0. With SIMPLE_PROC_ILLEGAL_EN: Illegal pulses and IllegalSticky stays 1 until Reset.
- Run toggled during T1..T3 of an add -> ignored; IR unchanged and sequence timing identical to the Run-low case.
